// File: rtl/mips_pkg.sv
// mips_pkg: shared control bundle, ALU op codes and the NOP control word.
package mips_pkg;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_RTYPE = 2'd3;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use stall request when the EX-stage load writes a register the ID instruction reads.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              stall_o
);
  // $0 is hardwired, so a load targeting it never creates a dependency
  assign stall_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i
                 & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic              RegDst_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_cnt;
  ctrl_t             w_ctrl_in;
  logic              w_stall, w_live, w_load_data, w_bubble;
  assign w_ctrl_in = '{reg_dst: RegDst_i, alu_src: ALUSrc_i, reg_write: RegWrite_i,
                       mem_read: MemRead_i, mem_write: MemWrite_i, mem_to_reg: MemtoReg_i,
                       alu_op: ALUOp_i};
  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i   (r_valid),
    .ex_mem_read_i(r_ctrl.mem_read),
    .ex_rt_i      (r_rt),
    .id_valid_i   (valid_i),
    .id_rs_i      (rs_i),
    .id_rt_i      (rt_i),
    .stall_o      (w_stall)
  );
  // flush outranks the bubble: a squashed slot loads data and is not counted
  assign w_bubble = w_stall & ~flush_i;
  assign w_live = valid_i & ~flush_i & ~w_stall;
  assign w_load_data = flush_i | ~w_stall;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_ctrl <= CTRL_NOP;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm <= '0;
      r_rs <= '0;
      r_rt <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (!stall_i) begin
      r_valid <= w_live;
      r_ctrl <= w_live ? w_ctrl_in : CTRL_NOP;
      if (w_load_data) begin
        r_rs_data <= rs_data_i;
        r_rt_data <= rt_data_i;
        r_imm <= imm_i;
        r_rs <= rs_i;
        r_rt <= rt_i;
        r_rd <= rd_i;
      end
      if (w_bubble && !(&r_cnt)) r_cnt <= r_cnt + CNT_ONE;
    end
  end
  assign stall_o = w_stall;
  assign valid_o = r_valid;
  assign RegDst_o = r_ctrl.reg_dst;
  assign ALUSrc_o = r_ctrl.alu_src;
  assign RegWrite_o = r_ctrl.reg_write;
  assign MemRead_o = r_ctrl.mem_read;
  assign MemWrite_o = r_ctrl.mem_write;
  assign MemtoReg_o = r_ctrl.mem_to_reg;
  assign ALUOp_o = r_ctrl.alu_op;
  assign rs_data_o = r_rs_data;
  assign rt_data_o = r_rt_data;
  assign imm_o = r_imm;
  assign rs_o = r_rs;
  assign rt_o = r_rt;
  assign rd_o = r_rd;
  assign bubble_cnt_o = r_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed checks of capture, load-use bubble, flush/hold priority, async reset and counter saturation.
module tb_id_ex_pipe;
  logic clk_i = 1'b0, rst_i, stall_i, flush_i, valid_i;
  logic RegDst_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
  logic [1:0] ALUOp_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic stall_o, valid_o, RegDst_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic [1:0] ALUOp_o;
  logic [31:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0] rs_o, rt_o, rd_o;
  logic [15:0] bubble_cnt_o;
  logic s_stall, s_valid, s_regdst, s_alusrc, s_regwrite, s_memread, s_memwrite, s_memtoreg;
  logic [1:0] s_aluop;
  logic [31:0] s_rs_data, s_rt_data, s_imm;
  logic [4:0] s_rs, s_rt, s_rd;
  logic [1:0] s_cnt;
  int total = 0, bad = 0;
  always #5 clk_i = ~clk_i;
  id_ex_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .ALUOp_i(ALUOp_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .stall_o(stall_o), .valid_o(valid_o), .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .ALUOp_o(ALUOp_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .bubble_cnt_o(bubble_cnt_o)
  );
  id_ex_pipe #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .ALUOp_i(ALUOp_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .stall_o(s_stall), .valid_o(s_valid), .RegDst_o(s_regdst), .ALUSrc_o(s_alusrc),
    .RegWrite_o(s_regwrite), .MemRead_o(s_memread), .MemWrite_o(s_memwrite),
    .MemtoReg_o(s_memtoreg), .ALUOp_o(s_aluop),
    .rs_data_o(s_rs_data), .rt_data_o(s_rt_data), .imm_o(s_imm),
    .rs_o(s_rs), .rt_o(s_rt), .rd_o(s_rd), .bubble_cnt_o(s_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic rtype(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd);
    valid_i = 1; RegDst_i = 1; ALUSrc_i = 0; RegWrite_i = 1; MemRead_i = 0;
    MemWrite_i = 0; MemtoReg_i = 0; ALUOp_i = 2'd3;
    rs_i = rs; rt_i = rt; rd_i = rd; rs_data_i = rsd; rt_data_i = rtd; imm_i = 32'h0;
  endtask
  task automatic lw(input logic [4:0] rs, rt, input logic [31:0] rsd, imm);
    valid_i = 1; RegDst_i = 0; ALUSrc_i = 1; RegWrite_i = 1; MemRead_i = 1;
    MemWrite_i = 0; MemtoReg_i = 1; ALUOp_i = 2'd0;
    rs_i = rs; rt_i = rt; rd_i = 5'd0; rs_data_i = rsd; rt_data_i = 32'h0; imm_i = imm;
  endtask
  initial begin
    rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
    RegDst_i = 0; ALUSrc_i = 0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
    ALUOp_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0; rs_i = 0; rt_i = 0; rd_i = 0;
    #1 rst_i = 1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ctrl", {RegDst_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUOp_o}, 0);
    chk("rst_data", rs_data_o | rt_data_o | imm_o, 0);
    chk("rst_addr", {rs_o, rt_o, rd_o}, 0);
    chk("rst_cnt", bubble_cnt_o, 0);
    chk("rst_stall", stall_o, 0);
    @(posedge clk_i);
    #3 rst_i = 0;
    rtype(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    step;
    chk("cap_valid", valid_o, 1);
    chk("cap_regdst", RegDst_o, 1);
    chk("cap_aluop", ALUOp_o, 3);
    chk("cap_rs_data", rs_data_o, 32'h11);
    chk("cap_rt_data", rt_data_o, 32'h22);
    chk("cap_rd", rd_o, 3);
    chk("cap_stall", stall_o, 0);
    lw(5'd4, 5'd8, 32'h100, 32'h4);
    step;
    chk("lw_memread", MemRead_o, 1);
    chk("lw_rt", rt_o, 8);
    rtype(5'd8, 5'd9, 5'd10, 32'h33, 32'h44);
    #1;
    chk("lu_stall_rs", stall_o, 1);
    step;
    chk("bub_valid", valid_o, 0);
    chk("bub_ctrl", {RegDst_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUOp_o}, 0);
    chk("bub_rs_data_hold", rs_data_o, 32'h100);
    chk("bub_rt_hold", rt_o, 8);
    chk("bub_cnt", bubble_cnt_o, 1);
    chk("bub_stall_drop", stall_o, 0);
    step;
    chk("dep_valid", valid_o, 1);
    chk("dep_rs", rs_o, 8);
    chk("dep_rs_data", rs_data_o, 32'h33);
    chk("dep_regwrite", RegWrite_o, 1);
    chk("dep_cnt", bubble_cnt_o, 1);
    lw(5'd4, 5'd0, 32'h200, 32'h8);
    step;
    rtype(5'd0, 5'd0, 5'd5, 32'h0, 32'h0);
    #1;
    chk("r0_stall", stall_o, 0);
    step;
    chk("r0_valid", valid_o, 1);
    chk("r0_cnt", bubble_cnt_o, 1);
    rtype(5'd6, 5'd7, 5'd11, 32'h77, 32'h88);
    flush_i = 1;
    step;
    chk("fl_valid", valid_o, 0);
    chk("fl_regwrite", RegWrite_o, 0);
    chk("fl_data_load", rs_data_o, 32'h77);
    chk("fl_cnt", bubble_cnt_o, 1);
    flush_i = 0;
    rtype(5'd12, 5'd13, 5'd14, 32'h55, 32'h56);
    step;
    chk("pre_hold_valid", valid_o, 1);
    rtype(5'd15, 5'd16, 5'd17, 32'h66, 32'h67);
    flush_i = 1; stall_i = 1;
    step;
    chk("hold_valid", valid_o, 1);
    chk("hold_regwrite", RegWrite_o, 1);
    chk("hold_rs_data", rs_data_o, 32'h55);
    chk("hold_rd", rd_o, 14);
    flush_i = 0; stall_i = 0;
    for (int i = 0; i < 4; i++) begin
      lw(5'd4, 5'd8, 32'h300 + i, 32'h0);
      step;
      if (i[0]) rtype(5'd1, 5'd8, 5'd2, 32'h9, 32'h9);
      else rtype(5'd8, 5'd1, 5'd2, 32'h9, 32'h9);
      #1;
      chk(i[0] ? "sat_stall_rt" : "sat_stall_rs", stall_o, 1);
      step;
    end
    chk("sat_cnt2", s_cnt, 3);
    chk("wide_cnt", bubble_cnt_o, 5);
    lw(5'd4, 5'd8, 32'h400, 32'h0);
    step;
    rtype(5'd8, 5'd3, 5'd2, 32'h9, 32'h9);
    stall_i = 1;
    #1;
    chk("hold_hz_stall", stall_o, 1);
    step;
    chk("hold_hz_cnt", bubble_cnt_o, 5);
    chk("hold_hz_memread", MemRead_o, 1);
    stall_i = 0;
    step;
    chk("post_hold_cnt", bubble_cnt_o, 6);
    chk("sat_cnt2_stays", s_cnt, 3);
    lw(5'd4, 5'd8, 32'h500, 32'h0);
    step;
    rtype(5'd8, 5'd3, 5'd2, 32'hab, 32'h9);
    #2 rst_i = 1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_memread", MemRead_o, 0);
    chk("arst_cnt", bubble_cnt_o, 0);
    chk("arst_sat_cnt", s_cnt, 0);
    chk("arst_stall", stall_o, 0);
    #1 rst_i = 0;
    step;
    chk("arst_load_valid", valid_o, 1);
    chk("arst_load_rs_data", rs_data_o, 32'hab);
    chk("arst_load_cnt", bubble_cnt_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS datapath. It sits directly downstream of the instruction-decode control unit and register file. It captures the decoded control bundle, operands, immediate and register addresses each cycle and presents them to the EX stage (ALU control, ALU source mux, destination mux). It requests a one-cycle stall on a load-use dependency and inserts a bubble. It also counts inserted bubbles for performance analysis.

## Interface
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register-address width
- CNT_W, 16, bubble-counter width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  downstream hold; freezes all registers
- flush_i  in  1  squash the instruction currently being captured (taken branch/jump)
- valid_i  in  1  ID stage holds a real instruction
- RegDst_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  decoded control
- ALUOp_i  in  2  decoded ALU op (0 = add/I-type, 3 = R-type)
- rs_data_i, rt_data_i, imm_i  in  DATA_W  operands, sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_AW  source/destination addresses
- stall_o  out  1  combinational load-use stall request to PC and IF/ID
- valid_o, RegDst_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALU op
- rs_data_o, rt_data_o, imm_o  out  DATA_W  registered operands
- rs_o, rt_o, rd_o  out  REG_AW  registered addresses
- bubble_cnt_o  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Hazard: stall_o = valid_o & MemRead_o & (rt_o != 0) & valid_i & ((rt_o == rs_i) | (rt_o == rt_i)).
- Per cycle, evaluate in this priority order:
  - **Reset:** rst_i clears every register and the counter to 0.
  - **Hold:** stall_i = 1 keeps all registers unchanged. The counter also holds. stall_o is still computed.
  - **Squash:** flush_i = 1 clears valid_o and all control outputs to 0. Data and address outputs load normally. This is not counted as a bubble.
  - **Bubble:** stall_o = 1 and flush_i = 0 clears valid_o and all control outputs to 0. Data and address outputs hold. bubble_cnt_o increments, saturating at all-ones.
  - **Load:** otherwise, all outputs capture inputs. valid_o = valid_i. If valid_i = 0, control outputs are loaded as 0.
- Only one bubble is inserted per load-use hazard. After the bubble, MemRead_o = 0, so stall_o drops and the held ID instruction loads the next cycle.
- Register address 0 never causes a hazard.

## Timing
- Capture latency: inputs at edge N appear on outputs after edge N.
- stall_o is purely combinational from registered EX state and current ID inputs. It has no cycle delay. Upstream must gate its own PC/IF-ID enables with it.
- Reset is asynchronous: outputs go to 0 immediately on rst_i rise, independent of the clock.
- Reset mid-bubble aborts the bubble. After release, the first edge performs a normal Load.
- stall_i and flush_i together: Hold wins. The flush must be re-presented by its source when the hold releases.
- Counter saturates at 2^CNT_W−1 and never wraps.

## Structure
- Shared package `mips_pkg`:
  - ctrl_t struct {reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg, alu_op[1:0]}
  - ALUOP_ADD = 2'd0, ALUOP_RTYPE = 2'd3
  - CTRL_NOP (all zero)
- Sub-module `hazard_detect`: the combinational stall_o equation. It is reused later by the IF/ID register.
- Top level: one ctrl_t register, data and address registers, and a saturating counter.

## Test plan
- Reset: assert rst_i with no clock edge → all outputs read 0 immediately; bubble_cnt_o = 0.
- Plain capture: R-type, ALUOp_i = 3, RegDst_i = 1, rs_data_i = 0x11, rt_data_i = 0x22, valid_i = 1 → next cycle the same values appear, valid_o = 1, stall_o = 0.
- Load-use: lw capturing rt_i = 8, then the ID instruction has rs_i = 8 → stall_o = 1 that cycle.
  - Next edge: control outputs = 0, rs_data_o holds, bubble_cnt_o = 1.
  - Following edge: the dependent instruction loads; stall_o = 0.
- Load to $0: lw with rt_i = 0 followed by rs_i = 0 → stall_o stays 0 and no bubble is counted.
- Flush vs hold:
  - flush_i = 1 with a valid instruction → valid_o = 0, RegWrite_o = 0, counter unchanged.
  - flush_i = 1 with stall_i = 1 → outputs unchanged.
- Saturation: preload the counter via CNT_W = 2 and force 4 hazards → bubble_cnt_o = 3 and stays at 3.
